pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the in-order RISC-V pipeline. It replaces the fixed two-stage forwarding and single-bubble load-use logic with several features:
- a scoreboard of in-flight destination records covering a configurable number of forwarding stages;
- configurable load latency;
- a pipeline-wide freeze for a variable-latency data memory;
- branch-redirect flush control;
- saturating event counters.

It sits beside the datapath. It takes decode-stage fields and drives the stall, flush, bubble and operand-mux selects.

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: a scoreboard of in-flight destination records that drives
// load-use stalls, memory freeze, redirect flush, EX operand forwarding and event counters.
module pipe_hazard_ctrl #(
   parameter int RF_ADDR_W = 5,
   parameter int NUM_FWD   = 2,
   parameter int LOAD_LAT  = 1,
   parameter int CNT_W     = 32,
   parameter int SEL_W     = $clog2(NUM_FWD + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic [RF_ADDR_W-1:0] id_rs1,
   input  logic [RF_ADDR_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [RF_ADDR_W-1:0] id_rd,
   input  logic                 id_regwrite,
   input  logic                 id_is_load,
   input  logic                 ex_redirect,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 stall_pc,
   output logic                 stall_ifid,
   output logic                 flush_ifid,
   output logic                 bubble_idex,
   output logic                 freeze,
   output logic [SEL_W-1:0]     fwd_sel_a,
   output logic [SEL_W-1:0]     fwd_sel_b,
   output logic [CNT_W-1:0]     cnt_loaduse,
   output logic [CNT_W-1:0]     cnt_freeze,
   output logic [CNT_W-1:0]     cnt_flush
);

   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] rd;
      logic                 regwrite;
      logic                 is_load;
   } dst_rec_t;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] rs1;
      logic [RF_ADDR_W-1:0] rs2;
      logic                 use1;
      logic                 use2;
   } src_rec_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   dst_rec_t rec [NUM_FWD+1];   // rec[0] = EX, rec[k] = k stages past EX
   src_rec_t ex_src;

   // x0 is hardwired zero, so a record naming it never produces a match
   function automatic logic writes(input dst_rec_t r, input logic [RF_ADDR_W-1:0] a);
      return r.valid && r.regwrite && (r.rd == a) && (a != '0);
   endfunction

   logic loaduse_hit;
   logic do_freeze, do_redirect, do_loaduse;

   always_comb begin
      loaduse_hit = 1'b0;
      for (int j = 0; j < LOAD_LAT; j++) begin
         if (rec[j].is_load &&
             ((id_use_rs1 && writes(rec[j], id_rs1)) ||
              (id_use_rs2 && writes(rec[j], id_rs2))))
            loaduse_hit = 1'b1;
      end
   end

   assign do_freeze   = ~reset & mem_req & ~mem_ready;
   assign do_redirect = ~reset & ~do_freeze & ex_redirect;
   assign do_loaduse  = ~reset & ~do_freeze & ~ex_redirect & id_valid & loaduse_hit;

   assign stall_pc    = do_freeze | do_loaduse;
   assign stall_ifid  = do_freeze | do_loaduse;
   assign flush_ifid  = do_redirect;
   assign bubble_idex = do_redirect | do_loaduse;
   assign freeze      = do_freeze;

   // Scan from the farthest stage down so the nearest matching producer wins
   always_comb begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      if (!reset && rec[0].valid) begin
         for (int k = NUM_FWD; k >= 1; k--) begin
            if (ex_src.use1 && writes(rec[k], ex_src.rs1)) fwd_sel_a = SEL_W'(k);
            if (ex_src.use2 && writes(rec[k], ex_src.rs2)) fwd_sel_b = SEL_W'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k <= NUM_FWD; k++) rec[k] <= '0;
         ex_src      <= '0;
         cnt_loaduse <= '0;
         cnt_freeze  <= '0;
         cnt_flush   <= '0;
      end else begin
         if (!do_freeze) begin
            for (int k = 1; k <= NUM_FWD; k++) rec[k] <= rec[k-1];
            if (do_redirect || do_loaduse) begin
               rec[0] <= '0;
               ex_src <= '0;
            end else begin
               rec[0] <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, is_load: id_is_load};
               ex_src <= '{rs1: id_rs1, rs2: id_rs2, use1: id_use_rs1, use2: id_use_rs2};
            end
         end
         if (do_loaduse && cnt_loaduse != CNT_MAX) cnt_loaduse <= cnt_loaduse + CNT_ONE;
         if (do_freeze && cnt_freeze != CNT_MAX)   cnt_freeze  <= cnt_freeze + CNT_ONE;
         if (do_redirect && cnt_flush != CNT_MAX)  cnt_flush   <= cnt_flush + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two configurations (NUM_FWD=2/LOAD_LAT=1 and
// NUM_FWD=3/LOAD_LAT=2, both CNT_W=4) share one stimulus stream.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic ex_redirect, mem_req, mem_ready;

   logic a_stall_pc, a_stall_ifid, a_flush_ifid, a_bubble_idex, a_freeze;
   logic b_stall_pc, b_stall_ifid, b_flush_ifid, b_bubble_idex, b_freeze;
   logic [1:0] a_sel_a, a_sel_b, b_sel_a, b_sel_b;
   logic [3:0] a_cnt_lu, a_cnt_fz, a_cnt_fl, b_cnt_lu, b_cnt_fz, b_cnt_fl;
   logic [4:0] ctl_a, ctl_b;

   int n_chk = 0;
   int n_fail = 0;

   // {stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze}
   assign ctl_a = {a_stall_pc, a_stall_ifid, a_flush_ifid, a_bubble_idex, a_freeze};
   assign ctl_b = {b_stall_pc, b_stall_ifid, b_flush_ifid, b_bubble_idex, b_freeze};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RF_ADDR_W(5), .NUM_FWD(2), .LOAD_LAT(1), .CNT_W(4)) u_a (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready), .stall_pc(a_stall_pc),
      .stall_ifid(a_stall_ifid), .flush_ifid(a_flush_ifid), .bubble_idex(a_bubble_idex),
      .freeze(a_freeze), .fwd_sel_a(a_sel_a), .fwd_sel_b(a_sel_b),
      .cnt_loaduse(a_cnt_lu), .cnt_freeze(a_cnt_fz), .cnt_flush(a_cnt_fl));

   pipe_hazard_ctrl #(.RF_ADDR_W(5), .NUM_FWD(3), .LOAD_LAT(2), .CNT_W(4)) u_b (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready), .stall_pc(b_stall_pc),
      .stall_ifid(b_stall_ifid), .flush_ifid(b_flush_ifid), .bubble_idex(b_bubble_idex),
      .freeze(b_freeze), .fwd_sel_a(b_sel_a), .fwd_sel_b(b_sel_b),
      .cnt_loaduse(b_cnt_lu), .cnt_freeze(b_cnt_fz), .cnt_flush(b_cnt_fl));

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld);
      id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      id_rd = rd; id_regwrite = rw; id_is_load = ld;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (4) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL rst_ctl_a: got %b expected 00000", ctl_a); end
      n_chk++; if (ctl_b !== 5'b00000) begin n_fail++; $display("FAIL rst_ctl_b: got %b expected 00000", ctl_b); end
      tick(); tick();
      @(negedge clk);
      n_chk++; if ({a_cnt_lu, a_cnt_fz, a_cnt_fl} !== 12'h000) begin n_fail++; $display("FAIL rst_cnt_a: got %h expected 000", {a_cnt_lu, a_cnt_fz, a_cnt_fl}); end
      n_chk++; if ({a_sel_a, a_sel_b, b_sel_a, b_sel_b} !== 8'h00) begin n_fail++; $display("FAIL rst_sel: got %h expected 00", {a_sel_a, a_sel_b, b_sel_a, b_sel_b}); end
      tick();
      reset = 1'b0; mem_req = 1'b0; ex_redirect = 1'b0;
      drain();
   endtask

   task automatic test_alu_fwd();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL alu_nostall_a: got %b expected 00000", ctl_a); end
      tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      @(negedge clk);
      n_chk++; if (a_sel_a !== 2'd1) begin n_fail++; $display("FAIL alu_sel1_a: got %0d expected 1", a_sel_a); end
      n_chk++; if (b_sel_a !== 2'd1) begin n_fail++; $display("FAIL alu_sel1_b: got %0d expected 1", b_sel_a); end
      n_chk++; if (ctl_b !== 5'b00000) begin n_fail++; $display("FAIL alu_nostall_b: got %b expected 00000", ctl_b); end
      tick();
      idle();
      @(negedge clk);
      n_chk++; if (a_sel_a !== 2'd2) begin n_fail++; $display("FAIL alu_sel2_a: got %0d expected 2", a_sel_a); end
      n_chk++; if (b_sel_a !== 2'd2) begin n_fail++; $display("FAIL alu_sel2_b: got %0d expected 2", b_sel_a); end
      tick();
      drain();
      // x5 produced in two consecutive stages: the nearer one must win on operand b
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick(); tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
      tick();
      idle();
      @(negedge clk);
      n_chk++; if (a_sel_b !== 2'd1) begin n_fail++; $display("FAIL alu_near_a: got %0d expected 1", a_sel_b); end
      n_chk++; if (b_sel_b !== 2'd1) begin n_fail++; $display("FAIL alu_near_b: got %0d expected 1", b_sel_b); end
      n_chk++; if (a_sel_a !== 2'd0) begin n_fail++; $display("FAIL alu_unused_a: got %0d expected 0", a_sel_a); end
      tick();
      drain();
   endtask

   task automatic test_load_use();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b11010) begin n_fail++; $display("FAIL lu_c1_a: got %b expected 11010", ctl_a); end
      n_chk++; if (ctl_b !== 5'b11010) begin n_fail++; $display("FAIL lu_c1_b: got %b expected 11010", ctl_b); end
      tick();
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL lu_c2_a: got %b expected 00000", ctl_a); end
      n_chk++; if (ctl_b !== 5'b11010) begin n_fail++; $display("FAIL lu_c2_b: got %b expected 11010", ctl_b); end
      tick();
      @(negedge clk);
      n_chk++; if (a_sel_a !== 2'd2) begin n_fail++; $display("FAIL lu_fwd_a: got %0d expected 2", a_sel_a); end
      n_chk++; if (a_cnt_lu !== 4'd1) begin n_fail++; $display("FAIL lu_cnt_a: got %0d expected 1", a_cnt_lu); end
      n_chk++; if (ctl_b !== 5'b00000) begin n_fail++; $display("FAIL lu_c3_b: got %b expected 00000", ctl_b); end
      tick();
      @(negedge clk);
      n_chk++; if (b_sel_a !== 2'd3) begin n_fail++; $display("FAIL lu_fwd_b: got %0d expected 3", b_sel_a); end
      n_chk++; if (b_cnt_lu !== 4'd2) begin n_fail++; $display("FAIL lu_cnt_b: got %0d expected 2", b_cnt_lu); end
      n_chk++; if (a_cnt_lu !== 4'd1) begin n_fail++; $display("FAIL lu_cnt_a2: got %0d expected 1", a_cnt_lu); end
      tick();
      drain();
   endtask

   task automatic test_x0();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL x0_stall_a: got %b expected 00000", ctl_a); end
      n_chk++; if (ctl_b !== 5'b00000) begin n_fail++; $display("FAIL x0_stall_b: got %b expected 00000", ctl_b); end
      tick();
      idle();
      @(negedge clk);
      n_chk++; if ({a_sel_a, a_sel_b, b_sel_a, b_sel_b} !== 8'h00) begin n_fail++; $display("FAIL x0_sel: got %h expected 00", {a_sel_a, a_sel_b, b_sel_a, b_sel_b}); end
      tick();
      drain();
   endtask

   task automatic test_freeze();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
      tick();
      idle();
      ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_chk++; if (ctl_a !== 5'b11001) begin n_fail++; $display("FAIL frz_ctl_a[%0d]: got %b expected 11001", i, ctl_a); end
         n_chk++; if (a_sel_a !== 2'd1) begin n_fail++; $display("FAIL frz_sel_a[%0d]: got %0d expected 1", i, a_sel_a); end
         tick();
      end
      n_chk++; if (b_cnt_fz !== 4'd4) begin n_fail++; $display("FAIL frz_cnt_b: got %0d expected 4", b_cnt_fz); end
      mem_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b00110) begin n_fail++; $display("FAIL frz_rel_a: got %b expected 00110", ctl_a); end
      n_chk++; if (a_cnt_fz !== 4'd4) begin n_fail++; $display("FAIL frz_cnt_a: got %0d expected 4", a_cnt_fz); end
      n_chk++; if (a_cnt_fl !== 4'd0) begin n_fail++; $display("FAIL frz_noflush_a: got %0d expected 0", a_cnt_fl); end
      tick();
      ex_redirect = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      n_chk++; if (a_cnt_fl !== 4'd1) begin n_fail++; $display("FAIL frz_flcnt_a: got %0d expected 1", a_cnt_fl); end
      n_chk++; if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL rdy_noreq_a: got %b expected 00000", ctl_a); end
      tick();
      mem_ready = 1'b0;
      drain();
   endtask

   task automatic test_redirect_loaduse();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      ex_redirect = 1'b1;
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b00110) begin n_fail++; $display("FAIL rdlu_ctl_a: got %b expected 00110", ctl_a); end
      n_chk++; if (ctl_b !== 5'b00110) begin n_fail++; $display("FAIL rdlu_ctl_b: got %b expected 00110", ctl_b); end
      tick();
      ex_redirect = 1'b0;
      idle();
      @(negedge clk);
      n_chk++; if (a_cnt_lu !== 4'd1) begin n_fail++; $display("FAIL rdlu_lu_a: got %0d expected 1", a_cnt_lu); end
      n_chk++; if (b_cnt_lu !== 4'd2) begin n_fail++; $display("FAIL rdlu_lu_b: got %0d expected 2", b_cnt_lu); end
      n_chk++; if (a_cnt_fl !== 4'd2) begin n_fail++; $display("FAIL rdlu_fl_a: got %0d expected 2", a_cnt_fl); end
      tick();
      drain();
   endtask

   task automatic test_reset_mid_stall();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b11010) begin n_fail++; $display("FAIL rms_pre_a: got %b expected 11010", ctl_a); end
      reset = 1'b1;
      #1;
      n_chk++; if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL rms_forced_a: got %b expected 00000", ctl_a); end
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_chk++; if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL rms_post_a: got %b expected 00000", ctl_a); end
      n_chk++; if (ctl_b !== 5'b00000) begin n_fail++; $display("FAIL rms_post_b: got %b expected 00000", ctl_b); end
      n_chk++; if ({a_cnt_lu, a_cnt_fz, a_cnt_fl} !== 12'h000) begin n_fail++; $display("FAIL rms_cnt_a: got %h expected 000", {a_cnt_lu, a_cnt_fz, a_cnt_fl}); end
      tick();
      idle();
      @(negedge clk);
      n_chk++; if (a_sel_a !== 2'd0) begin n_fail++; $display("FAIL rms_sel_a: got %0d expected 0", a_sel_a); end
      n_chk++; if (b_sel_a !== 2'd0) begin n_fail++; $display("FAIL rms_sel_b: got %0d expected 0", b_sel_a); end
      tick();
      drain();
   endtask

   task automatic test_saturation();
      ex_redirect = 1'b1;
      repeat (14) tick();
      @(negedge clk);
      n_chk++; if (a_cnt_fl !== 4'd14) begin n_fail++; $display("FAIL sat_14_a: got %0d expected 14", a_cnt_fl); end
      repeat (6) tick();
      ex_redirect = 1'b0;
      @(negedge clk);
      n_chk++; if (a_cnt_fl !== 4'd15) begin n_fail++; $display("FAIL sat_a: got %0d expected 15", a_cnt_fl); end
      n_chk++; if (b_cnt_fl !== 4'd15) begin n_fail++; $display("FAIL sat_b: got %0d expected 15", b_cnt_fl); end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      idle();
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_x0();
      test_freeze();
      test_redirect_loaduse();
      test_reset_mid_stall();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
